// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common data bus arbiter and its result FIFOs.
package cdb_arbiter_pkg;
  localparam int DEF_ROB_ID_WIDTH = 4;
  localparam int DEF_XLEN         = 32;
  localparam int DEF_FIFO_DEPTH   = 4;

  typedef logic [DEF_ROB_ID_WIDTH-1:0] rob_id_t;
  typedef logic [DEF_XLEN-1:0]         reg_t;

  typedef enum logic {
    CDB_SRC_RSS = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;
endpackage

// File: rtl/result_fifo.sv
// Small circular FIFO holding results from one producer until the CDB arbiter drains them.
module result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = en && !flush && push && !full;
  assign do_pop  = en && !flush && pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (do_push && !do_pop)      count <= count + 1'b1;
        else if (!do_push && do_pop) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining the RS and LSB result FIFOs onto one registered CDB per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_ID_WIDTH = DEF_ROB_ID_WIDTH,
  parameter int XLEN         = DEF_XLEN,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    rss_valid,
  input  logic [ROB_ID_WIDTH-1:0] rss_dest,
  input  logic [XLEN-1:0]         rss_value,
  input  logic [XLEN-1:0]         rss_next_pc,
  output logic                    rss_ready,
  input  logic                    lsb_valid,
  input  logic [ROB_ID_WIDTH-1:0] lsb_dest,
  input  logic [XLEN-1:0]         lsb_value,
  output logic                    lsb_ready,
  output logic [ROB_ID_WIDTH-1:0] cdb_dest,
  output logic [XLEN-1:0]         cdb_value,
  output logic [XLEN-1:0]         cdb_next_pc,
  output logic                    cdb_src
);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int RSS_W = ROB_ID_WIDTH + 2*XLEN;
  localparam int LSB_W = ROB_ID_WIDTH + XLEN;

  logic [RSS_W-1:0] rss_head;
  logic [LSB_W-1:0] lsb_head;
  logic [CW-1:0]    rss_count, lsb_count;
  logic             rss_full, rss_empty, lsb_full, lsb_empty;
  logic             rss_push, lsb_push, rss_pop, lsb_pop;
  logic             grant_rss, grant_lsb;
  cdb_src_e         last_grant;

  // Handshake: a result transfers on a cycle where valid && ready; ready comes only from
  // registered counts plus rdy/flush, and a transfer carrying tag 0 is accepted but dropped.
  assign rss_ready = rdy && !flush && (rss_count < CW'(FIFO_DEPTH));
  assign lsb_ready = rdy && !flush && (lsb_count < CW'(FIFO_DEPTH));
  assign rss_push  = rss_valid && rss_ready && !rss_full && (rss_dest != '0);
  assign lsb_push  = lsb_valid && lsb_ready && !lsb_full && (lsb_dest != '0);

  assign grant_rss = !rss_empty && (lsb_empty || last_grant == CDB_SRC_LSB);
  assign grant_lsb = !lsb_empty && !grant_rss;
  assign rss_pop   = rdy && !flush && grant_rss;
  assign lsb_pop   = rdy && !flush && grant_lsb;

  result_fifo #(.WIDTH(RSS_W), .DEPTH(FIFO_DEPTH)) u_rss_fifo (
    .clk(clk), .rst_n(rst_n), .en(rdy), .flush(flush),
    .push(rss_push), .push_data({rss_dest, rss_value, rss_next_pc}), .pop(rss_pop),
    .head(rss_head), .count(rss_count), .full(rss_full), .empty(rss_empty)
  );

  result_fifo #(.WIDTH(LSB_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk(clk), .rst_n(rst_n), .en(rdy), .flush(flush),
    .push(lsb_push), .push_data({lsb_dest, lsb_value}), .pop(lsb_pop),
    .head(lsb_head), .count(lsb_count), .full(lsb_full), .empty(lsb_empty)
  );

  // last_grant resets to LSB so the RS side wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_dest    <= '0;
      cdb_value   <= '0;
      cdb_next_pc <= '0;
      cdb_src     <= CDB_SRC_RSS;
      last_grant  <= CDB_SRC_LSB;
    end else if (rdy) begin
      if (flush) begin
        cdb_dest    <= '0;
        cdb_value   <= '0;
        cdb_next_pc <= '0;
        cdb_src     <= CDB_SRC_RSS;
        last_grant  <= CDB_SRC_LSB;
      end else if (grant_rss) begin
        {cdb_dest, cdb_value, cdb_next_pc} <= rss_head;
        cdb_src    <= CDB_SRC_RSS;
        last_grant <= CDB_SRC_RSS;
      end else if (grant_lsb) begin
        {cdb_dest, cdb_value} <= lsb_head;
        cdb_next_pc <= '0;
        cdb_src     <= CDB_SRC_LSB;
        last_grant  <= CDB_SRC_LSB;
      end else begin
        cdb_dest    <= '0;
        cdb_value   <= '0;
        cdb_next_pc <= '0;
        cdb_src     <= CDB_SRC_RSS;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table, directed corner sequences and a random phase.
module tb_cdb_arbiter;
  localparam int RW = 4;
  localparam int XL = 32;
  localparam int D  = 4;
  localparam int PW = 1 + RW + 2*XL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rdy, flush;
  logic          rss_valid, lsb_valid;
  logic [RW-1:0] rss_dest, lsb_dest;
  logic [XL-1:0] rss_value, rss_next_pc, lsb_value;
  logic          rss_ready, lsb_ready;
  logic [RW-1:0] cdb_dest;
  logic [XL-1:0] cdb_value, cdb_next_pc;
  logic          cdb_src;

  int checks = 0;
  int errors = 0;

  // Scoreboard: one expected queue per producer, words are {src, dest, value, next_pc}.
  logic [PW-1:0] rs_q[$];
  logic [PW-1:0] lsb_q[$];
  logic          lg;

  typedef struct {
    logic          r, f, rv, lv, es;
    logic [RW-1:0] rd, ld, ed;
    logic [XL-1:0] rval, rpc, lval, ev, epc;
  } vec_t;
  vec_t vecs[$];

  cdb_arbiter #(.ROB_ID_WIDTH(RW), .XLEN(XL), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .rss_valid(rss_valid), .rss_dest(rss_dest), .rss_value(rss_value),
    .rss_next_pc(rss_next_pc), .rss_ready(rss_ready),
    .lsb_valid(lsb_valid), .lsb_dest(lsb_dest), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
    .cdb_dest(cdb_dest), .cdb_value(cdb_value), .cdb_next_pc(cdb_next_pc), .cdb_src(cdb_src)
  );

  // Clock/reset
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] cdb_word();
    return {cdb_src, cdb_dest, cdb_value, cdb_next_pc};
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0;
    rss_valid = 1'b0; rss_dest = '0; rss_value = '0; rss_next_pc = '0;
    lsb_valid = 1'b0; lsb_dest = '0; lsb_value = '0;
  endtask

  task automatic drive_rs(input logic v, input logic [RW-1:0] d);
    rss_valid = v; rss_dest = d; rss_value = 32'h100 + 32'(d); rss_next_pc = 32'h200 + 32'(d);
  endtask

  task automatic drive_lsb(input logic v, input logic [RW-1:0] d);
    lsb_valid = v; lsb_dest = d; lsb_value = 32'h500 + 32'(d);
  endtask

  // One clock: predict the grant from the queued entries, then compare after the edge.
  task automatic step();
    logic          en, fl, acc_r, acc_l;
    logic [1:0]    pop_src;
    logic [PW-1:0] exp_w, prev_w;
    en     = rdy;
    fl     = flush;
    acc_r  = rss_valid && en && !fl && (rs_q.size() < D) && (rss_dest != '0);
    acc_l  = lsb_valid && en && !fl && (lsb_q.size() < D) && (lsb_dest != '0);
    prev_w = cdb_word();
    exp_w  = '0;
    pop_src = 2'd0;
    if (rs_q.size() > 0 && (lsb_q.size() == 0 || lg)) begin
      exp_w = rs_q[0]; pop_src = 2'd1;
    end else if (lsb_q.size() > 0) begin
      exp_w = lsb_q[0]; pop_src = 2'd2;
    end
    @(posedge clk);
    #1;
    if (!en) begin
      chk("hold_rdy_low", cdb_word(), prev_w);
    end else if (fl) begin
      rs_q.delete();
      lsb_q.delete();
      lg = 1'b1;
      chk("flush_cdb", cdb_word(), '0);
    end else begin
      if (pop_src == 2'd1) begin void'(rs_q.pop_front()); lg = 1'b0; end
      if (pop_src == 2'd2) begin void'(lsb_q.pop_front()); lg = 1'b1; end
      chk("cdb", cdb_word(), exp_w);
      if (acc_r) rs_q.push_back({1'b0, rss_dest, rss_value, rss_next_pc});
      if (acc_l) lsb_q.push_back({1'b1, lsb_dest, lsb_value, 32'h0});
    end
    chk("ready", PW'({rss_ready, lsb_ready}),
        PW'({rdy && !flush && rs_q.size() < D, rdy && !flush && lsb_q.size() < D}));
  endtask

  task automatic add(input logic r, f, rv, input logic [RW-1:0] rd, input logic [XL-1:0] rval, rpc,
                     input logic lv, input logic [RW-1:0] ld, input logic [XL-1:0] lval,
                     input logic [RW-1:0] ed, input logic es, input logic [XL-1:0] ev, epc);
    vec_t v;
    v.r = r; v.f = f; v.rv = rv; v.rd = rd; v.rval = rval; v.rpc = rpc;
    v.lv = lv; v.ld = ld; v.lval = lval; v.ed = ed; v.es = es; v.ev = ev; v.epc = epc;
    vecs.push_back(v);
  endtask

  function automatic logic [XL-1:0] rv_of(input int t); return 32'h100 + 32'(t); endfunction
  function automatic logic [XL-1:0] rp_of(input int t); return 32'h200 + 32'(t); endfunction
  function automatic logic [XL-1:0] lv_of(input int t); return 32'h500 + 32'(t); endfunction

  initial begin
    idle();
    lg = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cdb", cdb_word(), '0);
    chk("reset_ready", PW'({rss_ready, lsb_ready}), PW'(2'b11));
    @(negedge clk);
    rst_n = 1'b1;

    // Single RS push, tag-0 filtering, flush, then 4x4 contention ordering.
    add(1,0, 1,3,32'h11,32'h104, 0,0,0,      0,0,0,0);
    add(1,0, 0,0,0,0,            0,0,0,      3,0,32'h11,32'h104);
    add(1,0, 0,0,0,0,            0,0,0,      0,0,0,0);
    add(1,0, 0,0,0,0,            1,0,32'hdead, 0,0,0,0);
    add(1,0, 0,0,0,0,            0,0,0,      0,0,0,0);
    add(1,1, 0,0,0,0,            0,0,0,      0,0,0,0);
    add(1,0, 1,1,rv_of(1),rp_of(1), 1,5,lv_of(5), 0,0,0,0);
    add(1,0, 1,2,rv_of(2),rp_of(2), 1,6,lv_of(6), 1,0,rv_of(1),rp_of(1));
    add(1,0, 1,3,rv_of(3),rp_of(3), 1,7,lv_of(7), 5,1,lv_of(5),0);
    add(1,0, 1,4,rv_of(4),rp_of(4), 1,8,lv_of(8), 2,0,rv_of(2),rp_of(2));
    add(1,0, 0,0,0,0,            0,0,0,      6,1,lv_of(6),0);
    add(1,0, 0,0,0,0,            0,0,0,      3,0,rv_of(3),rp_of(3));
    add(1,0, 0,0,0,0,            0,0,0,      7,1,lv_of(7),0);
    add(1,0, 0,0,0,0,            0,0,0,      4,0,rv_of(4),rp_of(4));
    add(1,0, 0,0,0,0,            0,0,0,      8,1,lv_of(8),0);
    add(1,0, 0,0,0,0,            0,0,0,      0,0,0,0);
    for (int i = 0; i < vecs.size(); i++) begin
      rdy = vecs[i].r; flush = vecs[i].f;
      rss_valid = vecs[i].rv; rss_dest = vecs[i].rd; rss_value = vecs[i].rval; rss_next_pc = vecs[i].rpc;
      lsb_valid = vecs[i].lv; lsb_dest = vecs[i].ld; lsb_value = vecs[i].lval;
      step();
      chk($sformatf("vec%0d", i), cdb_word(), {vecs[i].es, vecs[i].ed, vecs[i].ev, vecs[i].epc});
    end

    // Five back-to-back RS pushes: each is accepted because one entry drains per cycle.
    idle();
    for (int t = 1; t <= 5; t++) begin
      drive_rs(1'b1, RW'(t));
      step();
    end
    idle();
    repeat (3) step();

    // Fill the RS FIFO under contention, then freeze with rdy low and a pending push.
    begin
      int n = 0;
      while (rs_q.size() < D && n < 20) begin
        drive_rs(1'b1, RW'(n % 15 + 1));
        drive_lsb(1'b1, RW'((n + 7) % 15 + 1));
        step();
        n++;
      end
      checks++;
      if (rs_q.size() != D) begin
        errors++;
        $display("FAIL fill_timeout: actual %0d entries required %0d", rs_q.size(), D);
      end
    end
    drive_lsb(1'b0, '0);
    drive_rs(1'b1, 4'd9);
    rdy = 1'b0;
    repeat (3) step();
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic will;
      will = (rs_q.size() < D);
      step();
      if (will) break;
    end
    idle();
    repeat (12) step();

    // Flush mid-burst: tag 9 offered in the flush cycle must never be broadcast.
    drive_rs(1'b1, 4'd1); drive_lsb(1'b1, 4'd5); step();
    drive_rs(1'b1, 4'd3); drive_lsb(1'b1, 4'd6); step();
    drive_rs(1'b1, 4'd4); drive_lsb(1'b0, '0);   step();
    drive_rs(1'b1, 4'd9); flush = 1'b1;          step();
    flush = 1'b0; drive_rs(1'b1, 4'd2);          step();
    idle();                                      step();
    chk("flush_next_tag", PW'(cdb_dest), PW'(2));
    repeat (3) step();

    // Asynchronous reset in mid-cycle with entries queued.
    for (int t = 1; t <= 3; t++) begin
      drive_rs(1'b1, RW'(t)); drive_lsb(1'b1, RW'(t + 10));
      step();
    end
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_cdb", cdb_word(), '0);
    rs_q.delete();
    lsb_q.delete();
    lg = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    // Random traffic with occasional stalls and flushes.
    for (int c = 0; c < 400; c++) begin
      rdy         = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 39) == 0);
      rss_valid   = $urandom_range(0, 1);
      rss_dest    = RW'($urandom_range(0, 15));
      rss_value   = $urandom;
      rss_next_pc = $urandom;
      lsb_valid   = $urandom_range(0, 1);
      lsb_dest    = RW'($urandom_range(0, 15));
      lsb_value   = $urandom;
      step();
    end
    idle();
    for (int c = 0; c < 30 && (rs_q.size() + lsb_q.size()) > 0; c++) step();
    step();
    chk("drain_empty", PW'(rs_q.size() + lsb_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares one common data bus (CDB) between the two result producers: the reservation-station ALU results and the load/store buffer load results. Each producer pushes results into its own small FIFO. A round-robin arbiter drains one entry per cycle onto a registered CDB. The ROB, reservation stations and LSB all snoop that CDB. The block absorbs bursts from both producers, so neither producer needs to know about the other, and it is cleared by the ROB mispredict flush.

## Interface
Parameters:
- `ROB_ID_WIDTH`, 4: ROB tag width. Tag 0 means "no result".
- `XLEN`, 32: value and PC width.
- `FIFO_DEPTH`, 4: entries per producer FIFO. Must be a power of two, at least 2.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rdy` in 1: global enable. When low, all state freezes.
- `flush` in 1: ROB mispredict flush (`reset_to_rob_bus`), synchronous.
- `rss_valid` in 1: RS result valid.
- `rss_dest` in `ROB_ID_WIDTH`: RS result ROB tag.
- `rss_value` in `XLEN`: RS result value.
- `rss_next_pc` in `XLEN`: resolved next PC for branches.
- `rss_ready` out 1: RS FIFO can accept.
- `lsb_valid` in 1: load result valid.
- `lsb_dest` in `ROB_ID_WIDTH`: load ROB tag.
- `lsb_value` in `XLEN`: loaded value.
- `lsb_ready` out 1: LSB FIFO can accept.
- `cdb_dest` out `ROB_ID_WIDTH`: broadcast tag. 0 means idle.
- `cdb_value` out `XLEN`: broadcast value.
- `cdb_next_pc` out `XLEN`: next PC. 0 for LSB entries.
- `cdb_src` out 1: source of the broadcast. 0 = RS, 1 = LSB.

## Operation
- **Push**
  - A push happens when `x_valid && x_ready && x_dest != 0`.
  - A push with tag 0 is dropped silently.
  - The pushed entry is written at the FIFO write pointer. The write pointer and count are incremented.
- **Ready**
  - `x_ready = rdy && !flush && count_x < FIFO_DEPTH`.
  - Ready depends only on registered count, with no combinational path from the grant.
  - A push and a pop on the same full FIFO in the same cycle cannot happen, because ready is already low.
- **Arbitration**, evaluated each enabled cycle:
  - Both FIFOs empty: no grant. `cdb_dest` is registered to 0. `cdb_value`, `cdb_next_pc` and `cdb_src` are registered to 0.
  - Exactly one FIFO non-empty: that FIFO is granted.
  - Both FIFOs non-empty: grant the source opposite to the register `last_grant`.
  - On a grant, pop the head entry into the CDB registers and set `last_grant` to the granted source.
- **Simultaneous push and pop on one FIFO**: both take effect and the count is unchanged. A push into an empty FIFO is not visible to the arbiter until the next cycle (no bypass).
- **Flush** has priority over push, pop and grant:
  - All FIFO pointers and counts go to 0.
  - `cdb_*` go to 0.
  - `last_grant` goes to 1, so RS wins the next tie.
  - Entries arriving in the flush cycle are discarded.
- **`rdy` low**: no push, no pop. Pointers, counts, `last_grant` and `cdb_*` all hold.
- **Pointer arithmetic**
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally modulo `FIFO_DEPTH`.
  - Counts are `$clog2(FIFO_DEPTH)+1` bits, ranging 0 to `FIFO_DEPTH`.

## Timing
- **Reset** (`rst_n` low, asynchronous): `cdb_dest`, `cdb_value`, `cdb_next_pc`, `cdb_src` = 0; `last_grant` = 1; all pointers and counts = 0. `rss_ready` and `lsb_ready` then follow their formula (1 when `rdy=1` and `flush=0`).
- Reset mid-operation discards all queued results immediately; no partial broadcast.
- **Latency**: an entry sampled at edge E into an empty FIFO with no contention appears on the CDB after edge E+1, and is held for exactly one cycle.
- **Throughput**: 1 broadcast per cycle total.
- **Fairness**: under sustained contention, broadcasts alternate RS, LSB, RS, LSB.
- **Worst-case wait**: an entry waits at most 2×`FIFO_DEPTH`−1 grants.

## Structure
- Shared constants belong in `config.v`:
  - the `ROB_ID_WIDTH` / `RO_BUFFER_ID_TYPE` range;
  - `REG_TYPE`;
  - `CDB_SRC_RSS` = 0 and `CDB_SRC_LSB` = 1;
  - the default FIFO depth.
- Sub-module `result_fifo`:
  - Parameterised payload width and depth; async active-low reset; `flush`.
  - Ports: push, pop, head data, count, full, empty.
  - Instantiated twice: RS payload = dest+value+next_pc; LSB payload = dest+value.
- Arbiter and CDB registers live in `cdb_arbiter` itself.

## Test plan
- **Single RS push**: push `rss_dest=3`, `value=0x11`, `next_pc=0x104` at edge E → CDB shows `dest=3`, `value=0x11`, `next_pc=0x104`, `src=0` after E+1; `cdb_dest=0` after E+2.
- **Contention**: fill both FIFOs with 4 entries each (RS tags 1–4, LSB tags 5–8), with `last_grant=1` → CDB order is 1, 5, 2, 6, 3, 7, 4, 8. `rss_ready` and `lsb_ready` are low while count is 4.
- **Full boundary**: 5 back-to-back RS pushes with the LSB idle → all 5 accepted, because one entry drains per cycle. With the CDB pop blocked by `rdy` low after 4 pushes → `rss_ready` = 0 and the 5th push is not accepted until `rdy` returns high.
- **Tag-0 filtering**: `lsb_valid=1` with `lsb_dest=0` → no FIFO entry; CDB stays idle.
- **Flush mid-burst**: 3 RS and 2 LSB entries queued, `flush` pulsed for one cycle alongside a new push with tag 9 → CDB = 0 after the edge, tag 9 is never broadcast, and the next RS push (tag 2) appears after 2 edges.
- **Async reset**: `rst_n` dropped mid-cycle with entries queued → all `cdb_*` are 0 immediately without a clock edge, and FIFOs are empty after `rst_n` is released.
